// File: rtl/dma_irq_ctrl.sv
// dma_irq_ctrl: interrupt/coalescing stage behind the DMA wrapper status outputs.
// Descriptor completions are coalesced by a count threshold and an idle timeout.
// Whole-transfer done and error pulses are latched directly.
// All pending bits are write-1-to-clear and merged into one registered level interrupt.
module dma_irq_ctrl #(
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             desc_done_i,
    input  logic             dma_done_i,
    input  logic             dma_err_i,
    input  logic [2:0]       irq_en_i,
    input  logic [CNT_W-1:0] coal_thr_i,
    input  logic [TMO_W-1:0] coal_tmo_i,
    input  logic [3:0]       clr_i,
    output logic [3:0]       status_o,
    output logic [CNT_W-1:0] batch_o,
    output logic [CNT_W-1:0] coal_cnt_o,
    output logic             irq_o
);

    // Bit positions inside status_o / clr_i.
    localparam int ST_COAL = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;
    localparam int ST_OVF  = 3;

    // IDLE holds exactly when no completions are pending (cnt == 0).
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W-1:0] batch_next;
    logic [TMO_W-1:0] tmr, tmr_next;
    logic             sat;
    logic             thr_hit;
    logic             tmo_hit;
    logic             flush;
    logic             fire;
    logic             ovf_set;
    logic [3:0]       status_set;
    logic [3:0]       status_next;
    logic             irq_next;

    // Coalescing decisions, FSM next state, and next status/irq values.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
        state_next  = state;
        cnt_next    = cnt;
        tmr_next    = tmr;
        batch_next  = batch_o;

        // A threshold of zero behaves like one: every completion fires.
        thr_eff = (coal_thr_i == '0) ? CNT_W'(1) : coal_thr_i;

        // Count including a same-cycle completion; a completion arriving
        // while the counter is saturated is dropped (and flagged as overflow).
        sat     = &cnt;
        cnt_inc = (desc_done_i && !sat) ? cnt + CNT_W'(1) : cnt;

        // Threshold is only evaluated on a completion, so lowering the
        // threshold below the current count never fires spontaneously.
        thr_hit = desc_done_i && (cnt_inc >= thr_eff);

        // Timeout only while accumulating, and only if the threshold did
        // not already fire this cycle. >= also covers a timeout lowered
        // below a timer that has already stopped.
        tmo_hit = (state == ACCUM) && (coal_tmo_i != '0) &&
                  (tmr >= coal_tmo_i) && !thr_hit;

        // End of transfer flushes whatever is pending, including a
        // completion arriving in the same cycle.
        flush = dma_done_i && (cnt_inc != '0);

        fire = thr_hit || tmo_hit || flush;

        if (fire) begin
            batch_next = cnt_inc;
            cnt_next   = '0;
            tmr_next   = '0;
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (desc_done_i) begin
                        cnt_next   = CNT_W'(1);
                        // Timer is held at zero while the timeout is disabled.
                        tmr_next   = (coal_tmo_i == '0) ? '0 : TMO_W'(1);
                        state_next = ACCUM;
                    end
                end
                ACCUM: begin
                    cnt_next = cnt_inc;
                    // Timer never wraps: it stops at the timeout value.
                    if (coal_tmo_i == '0) begin
                        tmr_next = '0;
                    end else if (tmr < coal_tmo_i) begin
                        tmr_next = tmr + TMO_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Overflow: a fire lands on a still-pending coal bit, or a completion
        // is dropped because the counter is saturated.
        ovf_set = (fire && status_o[ST_COAL] && !clr_i[ST_COAL]) ||
                  (desc_done_i && sat);

        status_set              = '0;
        status_set[ST_COAL]     = fire;
        status_set[ST_DONE]     = dma_done_i;
        status_set[ST_ERR]      = dma_err_i;
        status_set[ST_OVF]      = ovf_set;

        // A set in the same cycle as its clear wins.
        status_next = (status_o & ~clr_i) | status_set;

        // Overflow is informational only and never raises the interrupt.
        irq_next = |(status_next[2:0] & irq_en_i);
    end

    // State, counters and all registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            tmr      <= '0;
            status_o <= '0;
            batch_o  <= '0;
            irq_o    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            tmr      <= tmr_next;
            status_o <= status_next;
            batch_o  <= batch_next;
            irq_o    <= irq_next;
        end
    end

    assign coal_cnt_o = cnt;

endmodule

// File: tb/tb_dma_irq_ctrl.sv
// Directed self-checking bench for dma_irq_ctrl.
module tb_dma_irq_ctrl;

    localparam int CNT_W = 8;
    localparam int TMO_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             desc_done_i;
    logic             dma_done_i;
    logic             dma_err_i;
    logic [2:0]       irq_en_i;
    logic [CNT_W-1:0] coal_thr_i;
    logic [TMO_W-1:0] coal_tmo_i;
    logic [3:0]       clr_i;
    logic [3:0]       status_o;
    logic [CNT_W-1:0] batch_o;
    logic [CNT_W-1:0] coal_cnt_o;
    logic             irq_o;

    int errors = 0;
    int checks = 0;

    dma_irq_ctrl #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .desc_done_i (desc_done_i),
        .dma_done_i  (dma_done_i),
        .dma_err_i   (dma_err_i),
        .irq_en_i    (irq_en_i),
        .coal_thr_i  (coal_thr_i),
        .coal_tmo_i  (coal_tmo_i),
        .clr_i       (clr_i),
        .status_o    (status_o),
        .batch_o     (batch_o),
        .coal_cnt_o  (coal_cnt_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    // Hard bound on run time.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1 ns later and pulses dropped.
    task automatic tick();
        @(posedge clk);
        #1;
        desc_done_i = 1'b0;
        dma_done_i  = 1'b0;
        dma_err_i   = 1'b0;
        clr_i       = 4'b0000;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            desc_done_i = 1'b1;
            tick();
        end
    endtask

    initial begin
        rst         = 1'b1;
        desc_done_i = 1'b0;
        dma_done_i  = 1'b0;
        dma_err_i   = 1'b0;
        irq_en_i    = 3'b000;
        coal_thr_i  = '0;
        coal_tmo_i  = '0;
        clr_i       = 4'b0000;
        tick();
        tick();
        check("rst_status", status_o, 4'b0000);
        check("rst_batch", batch_o, 0);
        check("rst_cnt", coal_cnt_o, 0);
        check("rst_irq", irq_o, 0);
        rst = 1'b0;

        // Threshold 4, no timeout
        coal_thr_i = 8'd4;
        coal_tmo_i = 16'd0;
        irq_en_i   = 3'b001;
        pulses(1);
        check("thr_cnt1", coal_cnt_o, 1);
        pulses(2);
        check("thr_cnt3", coal_cnt_o, 3);
        check("thr_nofire", status_o, 4'b0000);
        pulses(1);
        check("thr_status", status_o, 4'b0001);
        check("thr_batch", batch_o, 4);
        check("thr_cnt0", coal_cnt_o, 0);
        check("thr_irq", irq_o, 1);
        clr_i = 4'b0001;
        tick();
        check("thr_clr_status", status_o, 4'b0000);
        check("thr_clr_irq", irq_o, 0);

        // Timeout 10, threshold 8: 3 pulses from cycle N, fire seen at N+11
        coal_thr_i = 8'd8;
        coal_tmo_i = 16'd10;
        pulses(3);
        check("tmo_cnt3", coal_cnt_o, 3);
        for (int i = 0; i < 7; i++) tick();
        check("tmo_early", status_o, 4'b0000);
        check("tmo_early_cnt", coal_cnt_o, 3);
        tick();
        check("tmo_status", status_o, 4'b0001);
        check("tmo_batch", batch_o, 3);
        check("tmo_cnt0", coal_cnt_o, 0);
        check("tmo_irq", irq_o, 1);
        clr_i = 4'b0001;
        tick();
        coal_tmo_i = 16'd0;

        // Flush on dma_done
        pulses(2);
        check("flush_cnt2", coal_cnt_o, 2);
        dma_done_i = 1'b1;
        tick();
        check("flush_status", status_o, 4'b0011);
        check("flush_batch", batch_o, 2);
        check("flush_cnt0", coal_cnt_o, 0);
        check("flush_irq", irq_o, 1);
        clr_i = 4'b0011;
        tick();
        check("flush_clr", status_o, 4'b0000);
        check("flush_clr_irq", irq_o, 0);

        // dma_done with nothing pending: done only, batch untouched
        dma_done_i = 1'b1;
        tick();
        check("done_idle_status", status_o, 4'b0010);
        check("done_idle_batch", batch_o, 2);
        clr_i = 4'b0010;
        tick();

        // Error and mask
        irq_en_i  = 3'b000;
        dma_err_i = 1'b1;
        tick();
        check("err_status", status_o, 4'b0100);
        check("err_irq_masked", irq_o, 0);
        irq_en_i = 3'b100;
        tick();
        check("err_irq_unmask", irq_o, 1);
        irq_en_i = 3'b000;
        tick();
        check("err_irq_remask", irq_o, 0);
        clr_i = 4'b0100;
        tick();
        check("err_clr", status_o, 4'b0000);

        // Threshold 1: set beats clear, then overflow
        irq_en_i    = 3'b001;
        coal_thr_i  = 8'd1;
        desc_done_i = 1'b1;
        clr_i       = 4'b0001;
        tick();
        check("setwin_status", status_o, 4'b0001);
        check("setwin_batch", batch_o, 1);
        check("setwin_irq", irq_o, 1);
        pulses(1);
        check("ovf_status", status_o, 4'b1001);
        clr_i = 4'b0001;
        tick();
        check("ovf_only_status", status_o, 4'b1000);
        check("ovf_only_irq", irq_o, 0);
        clr_i = 4'b1000;
        tick();
        check("ovf_clr", status_o, 4'b0000);

        // Threshold 0 acts as 1
        coal_thr_i = 8'd0;
        pulses(1);
        check("thr0_status", status_o, 4'b0001);
        check("thr0_cnt", coal_cnt_o, 0);
        clr_i = 4'b0001;
        tick();

        // Reset mid-accumulation discards the count
        coal_thr_i = 8'd8;
        pulses(5);
        check("rst_mid_cnt5", coal_cnt_o, 5);
        rst = 1'b1;
        tick();
        check("rst_mid_status", status_o, 4'b0000);
        check("rst_mid_batch", batch_o, 0);
        check("rst_mid_cnt", coal_cnt_o, 0);
        check("rst_mid_irq", irq_o, 0);
        rst = 1'b0;
        pulses(1);
        check("restart_cnt1", coal_cnt_o, 1);

        // Lowering threshold below count fires only on next completion
        pulses(2);
        check("lower_cnt3", coal_cnt_o, 3);
        coal_thr_i = 8'd2;
        tick();
        check("lower_nospont", status_o, 4'b0000);
        check("lower_hold_cnt", coal_cnt_o, 3);
        pulses(1);
        check("lower_status", status_o, 4'b0001);
        check("lower_batch", batch_o, 4);
        check("lower_irq", irq_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
